// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, GF(2^8) constant multipliers, engine FSM states.
package aes_pkg;

    localparam int BYTE     = 8;
    localparam int WORD     = 32;
    localparam int SENTENCE = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multiply built from xtime chains; covers every MixColumns coefficient.
    function automatic logic [BYTE-1:0] gf_mul_const(input logic [BYTE-1:0] x,
                                                     input logic [BYTE-1:0] c);
        logic [BYTE-1:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            8'h01:   return x;
            8'h02:   return x2;
            8'h03:   return x2 ^ x;
            8'h09:   return x8 ^ x;
            8'h0b:   return x8 ^ x2 ^ x;
            8'h0d:   return x8 ^ x4 ^ x;
            8'h0e:   return x8 ^ x4 ^ x2;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/gf_mix_column.sv
// Combinational single-column mixer, forward or inverse MixColumns.
module gf_mix_column
    import aes_pkg::*;
(
    input  logic [WORD-1:0] col_in,
    input  logic            inv,
    output logic [WORD-1:0] col_out
);

    // Row 0 coefficients; row r is row 0 rotated right by r. Index 3 pairs with b0 (MSB).
    localparam logic [3:0][BYTE-1:0] FWD_ROW0 = {8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [3:0][BYTE-1:0] INV_ROW0 = {8'h0e, 8'h0b, 8'h0d, 8'h09};

    logic [3:0][BYTE-1:0] b;
    logic [3:0][BYTE-1:0] row0;
    logic [3:0][BYTE-1:0] o;

    assign b       = col_in;
    assign row0    = inv ? INV_ROW0 : FWD_ROW0;
    assign col_out = o;

    // Each output byte r is the XOR of b_j * row0[(j - r) mod 4].
    always_comb begin
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                o[3-r] = o[3-r] ^ gf_mul_const(b[3-j], row0[3-((j-r+4)%4)]);
            end
        end
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns engine: one state per handshake, COLS_PER_CYCLE columns per clock.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inValid,
    output logic                inReady,
    input  logic [SENTENCE-1:0] inpt,
    input  logic                inv,
    output logic                outValid,
    input  logic                outReady,
    output logic [SENTENCE-1:0] oupt,
    output logic                busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // A step of 4 truncates to 0, so col_idx stays 0 and the single RUN cycle is also the last.
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);

    fsm_e                  fsm_q;
    logic [1:0]            col_idx;
    logic [3:0][WORD-1:0]  state_q;   // index 3 holds column 0
    logic [3:0][WORD-1:0]  state_d;
    logic                  mode_q;

    logic [COLS_PER_CYCLE-1:0][WORD-1:0] mix_in;
    logic [COLS_PER_CYCLE-1:0][WORD-1:0] mix_out;
    logic [COLS_PER_CYCLE-1:0][1:0]      slot;

    // One mixer per lane; lane g works on column col_idx+g, stored at packed index ~(col_idx+g).
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
        assign slot[g]   = ~(col_idx + 2'(g));
        assign mix_in[g] = state_q[slot[g]];
        gf_mix_column u_mix (
            .col_in  (mix_in[g]),
            .inv     (mode_q),
            .col_out (mix_out[g])
        );
    end

    // Write the mixed group back in place; other columns pass through.
    always_comb begin
        state_d = state_q;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            state_d[slot[g]] = mix_out[g];
        end
    end

    // Control FSM, column counter, state and mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            col_idx <= 2'd0;
            state_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (inValid) begin
                        state_q <= inpt;
                        mode_q  <= inv;
                        col_idx <= 2'd0;
                        fsm_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_q <= state_d;
                    col_idx <= col_idx + STEP;
                    if (col_idx == LAST_IDX) fsm_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (outReady) fsm_q <= ST_IDLE;
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign inReady  = (fsm_q == ST_IDLE);
    assign outValid = (fsm_q == ST_DONE);
    assign busy     = (fsm_q == ST_RUN) || (fsm_q == ST_DONE);
    assign oupt     = state_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4.
module tb_mix_columns_seq;

    localparam logic [127:0] V_A  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V_AF = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V_B  = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
    localparam logic [127:0] V_BF = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] inpt;
    logic         inv;
    logic [2:0]   in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] oupt_a [3];
    int           total = 0;
    int           bad   = 0;
    int           cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .inValid(in_valid[0]), .inReady(in_ready[0]),
        .inpt(inpt), .inv(inv), .outValid(out_valid[0]), .outReady(out_ready[0]),
        .oupt(oupt_a[0]), .busy(busy[0]));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .inValid(in_valid[1]), .inReady(in_ready[1]),
        .inpt(inpt), .inv(inv), .outValid(out_valid[1]), .outReady(out_ready[1]),
        .oupt(oupt_a[1]), .busy(busy[1]));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .inValid(in_valid[2]), .inReady(in_ready[2]),
        .inpt(inpt), .inv(inv), .outValid(out_valid[2]), .outReady(out_ready[2]),
        .oupt(oupt_a[2]), .busy(busy[2]));

    // Reference: generic shift-and-add GF(2^8) multiply and explicit coefficient matrices.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] ref_col(input logic [31:0] c, input logic m);
        logic [7:0] row0 [4];
        logic [7:0] bt [4];
        logic [7:0] r;
        logic [31:0] o;
        if (m) row0 = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else   row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < 4; i++) bt[i] = c[31-8*i -: 8];
        o = 32'h0;
        for (int ri = 0; ri < 4; ri++) begin
            r = 8'h00;
            for (int j = 0; j < 4; j++) r = r ^ gmul(bt[j], row0[(j - ri + 4) % 4]);
            o[31-8*ri -: 8] = r;
        end
        return o;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s, input logic m);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = ref_col(s[127-32*c -: 32], m);
        return o;
    endfunction

    // Push one block into instance k with outReady high; check latency, result, return to IDLE.
    task automatic run_block(input int k, input logic [127:0] d, input logic m,
                             input logic [127:0] exp, input string name);
        int lat, want;
        want = (k == 0) ? 4 : (k == 1) ? 2 : 1;
        @(negedge clk);
        inpt = d; inv = m; in_valid[k] = 1'b1; out_ready[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        total++;
        if (busy[k] !== 1'b1) begin
            bad++; $display("FAIL %s_busy k=%0d got=%b want=1", name, k, busy[k]);
        end
        lat = 0;
        while (out_valid[k] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        total++;
        if (lat != want) begin
            bad++; $display("FAIL %s_latency k=%0d got=%0d want=%0d", name, k, lat, want);
        end
        total++;
        if (oupt_a[k] !== exp) begin
            bad++; $display("FAIL %s_data k=%0d got=%h want=%h", name, k, oupt_a[k], exp);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
            bad++; $display("FAIL %s_idle k=%0d outValid=%b inReady=%b want 0/1",
                            name, k, out_valid[k], in_ready[k]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 ||
                oupt_a[k] !== 128'h0) begin
                bad++;
                $display("FAIL reset k=%0d inReady=%b outValid=%b busy=%b oupt=%h want 1/0/0/0",
                         k, in_ready[k], out_valid[k], busy[k], oupt_a[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_forward();
        for (int k = 0; k < 3; k++) run_block(k, V_A, 1'b0, V_AF, "fwd");
    endtask

    task automatic test_inverse();
        for (int k = 0; k < 3; k++) run_block(k, V_AF, 1'b1, V_A, "inv");
    endtask

    task automatic test_width_sweep();
        for (int k = 0; k < 3; k++) begin
            run_block(k, V_B, 1'b0, V_BF, "sweep_fwd");
            run_block(k, V_BF, 1'b1, V_B, "sweep_inv");
        end
    endtask

    task automatic test_backpressure();
        int t;
        @(negedge clk);
        inpt = V_A; inv = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        t = 0;
        while (out_valid[0] !== 1'b1 && t < 20) begin
            @(posedge clk); #1; t++;
        end
        total++;
        if (out_valid[0] !== 1'b1) begin
            bad++; $display("FAIL bp_timeout got outValid=%b want=1", out_valid[0]);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            inpt = V_B; inv = 1'b1; in_valid[0] = 1'b1;
            @(posedge clk); #1;
            total++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || oupt_a[0] !== V_AF) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d outValid=%b inReady=%b oupt=%h want 1/0/%h",
                         i, out_valid[0], in_ready[0], oupt_a[0], V_AF);
            end
        end
        @(negedge clk);
        in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || oupt_a[0] !== V_AF) begin
            bad++;
            $display("FAIL bp_release outValid=%b inReady=%b oupt=%h want 0/1/%h",
                     out_valid[0], in_ready[0], oupt_a[0], V_AF);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            bad++; $display("FAIL bp_single outValid=%b busy=%b want 0/0", out_valid[0], busy[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        inpt = V_A; inv = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1 ||
            oupt_a[0] !== 128'h0) begin
            bad++;
            $display("FAIL midrst outValid=%b busy=%b inReady=%b oupt=%h want 0/0/1/0",
                     out_valid[0], busy[0], in_ready[0], oupt_a[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
                bad++; $display("FAIL midrst_quiet cyc=%0d outValid=%b inReady=%b want 0/1",
                                i, out_valid[0], in_ready[0]);
            end
        end
        run_block(0, V_B, 1'b0, V_BF, "midrst_after");
    endtask

    task automatic test_back_to_back();
        logic [127:0] x, exp;
        int prev_acc, acc, t;
        out_ready[0] = 1'b1;
        prev_acc = -1;
        x = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        inpt = x; inv = 1'b0; in_valid[0] = 1'b1;
        for (int b = 0; b < 16; b++) begin
            exp = (b % 2 == 0) ? ref_state(x, 1'b0) : x;
            t = 0;
            while (in_ready[0] !== 1'b1 && t < 20) begin
                @(posedge clk); #1; t++;
            end
            @(posedge clk); #1;
            acc = cyc_cnt;
            in_valid[0] = 1'b0;
            if (prev_acc >= 0) begin
                total++;
                if (acc - prev_acc != 6) begin
                    bad++; $display("FAIL b2b_rate blk=%0d got=%0d want=6", b, acc - prev_acc);
                end
            end
            prev_acc = acc;
            t = 0;
            while (out_valid[0] !== 1'b1 && t < 20) begin
                @(posedge clk); #1; t++;
            end
            total++;
            if (oupt_a[0] !== exp) begin
                bad++; $display("FAIL b2b_data blk=%0d got=%h want=%h", b, oupt_a[0], exp);
            end
            if (b % 2 == 0) begin
                inpt = exp; inv = 1'b1;
            end else begin
                x = {$urandom, $urandom, $urandom, $urandom};
                inpt = x; inv = 1'b0;
            end
            in_valid[0] = (b != 15);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; inpt = '0; inv = 1'b0;
        in_valid = '0; out_ready = 3'b111;
        test_reset();
        test_forward();
        test_inverse();
        test_width_sweep();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
